// File: rtl/spi_wb_cmd_if_if.sv
// Bus bundle for the SPI command-ring front end: Wishbone slave signals plus
// port A of the command buffer shared with the SPI master.
interface spi_wb_cmd_if_if #(
    parameter int AW = 8
);
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic          wb_we_i;
    logic [1:0]    wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic [AW-1:0] buf_addra;
    logic [31:0]   buf_dina;
    logic          buf_wea;
    logic [31:0]   buf_douta;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, buf_douta,
        output wb_dat_o, wb_ack_o, wb_err_o, buf_addra, buf_dina, buf_wea
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, buf_douta,
        input  wb_dat_o, wb_ack_o, wb_err_o, buf_addra, buf_dina, buf_wea
    );
endinterface

// File: rtl/spi_wb_cmd_if.sv
// Wishbone front end that queues SPI commands into a ring in the shared
// buffer and hands completed (ready) slots back to software via RESULT.
module spi_wb_cmd_if #(
    parameter int AW = 8  // status word packs count/rd/wr into 3*AW+1 bits, so AW <= 9
) (
    input  logic            clk,
    input  logic            rst,
    spi_wb_cmd_if_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;
    typedef enum logic [1:0] {
        REG_CMD    = 2'd0,
        REG_RESULT = 2'd1,
        REG_STATUS = 2'd2,
        REG_RSVD   = 2'd3
    } reg_t;

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic        req;
    logic        can_accept;
    logic        full;
    logic        empty;
    logic [31:0] cmd_word;
    logic [31:0] status_word;
    logic        unused_dat_bits;

    assign req        = bus.wb_cyc_i & bus.wb_stb_i;
    // A transfer terminated on the previous edge still has cyc/stb high now;
    // refusing it here keeps ack/err to one-cycle pulses.
    assign can_accept = req & ~bus.wb_ack_o & ~bus.wb_err_o;
    assign full       = (count == DEPTH);
    assign empty      = (count == '0);

    // Freshly queued slots are marked busy and not ready for the SPI master.
    assign cmd_word   = {1'b0, 1'b1, bus.wb_dat_i[29], 14'b0, bus.wb_dat_i[14:0]};
    assign unused_dat_bits = ^{bus.wb_dat_i[31:30], bus.wb_dat_i[28:15]};

    always_comb begin
        status_word              = '0;
        status_word[3*AW:0]      = {count, rd_ptr, wr_ptr};
        status_word[31]          = full;
        status_word[30]          = empty;
    end

    // NOTE: every register here is state, so only non-blocking assignments are
    // used; the ring memory itself lives outside and is deliberately not reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.wb_ack_o  <= 1'b0;
            bus.wb_err_o  <= 1'b0;
            bus.wb_dat_o  <= '0;
            bus.buf_wea   <= 1'b0;
            bus.buf_addra <= '0;
            bus.buf_dina  <= '0;
        end else begin
            bus.wb_ack_o <= 1'b0;
            bus.wb_err_o <= 1'b0;
            bus.buf_wea  <= 1'b0;

            case (state)
                IDLE: begin
                    if (can_accept) begin
                        case (reg_t'(bus.wb_adr_i))
                            REG_CMD: begin
                                if (bus.wb_we_i && !full) begin
                                    bus.buf_addra <= wr_ptr;
                                    bus.buf_dina  <= cmd_word;
                                    bus.buf_wea   <= 1'b1;
                                    wr_ptr        <= wr_ptr + 1'b1;
                                    count         <= count + 1'b1;
                                    bus.wb_ack_o  <= 1'b1;
                                end else begin
                                    bus.wb_err_o  <= 1'b1;
                                end
                            end
                            REG_RESULT: begin
                                if (bus.wb_we_i) begin
                                    bus.wb_err_o  <= 1'b1;
                                end else begin
                                    bus.buf_addra <= rd_ptr;
                                    state         <= RD_WAIT;
                                end
                            end
                            REG_STATUS: begin
                                if (bus.wb_we_i) begin
                                    bus.wb_err_o  <= 1'b1;
                                end else begin
                                    bus.wb_dat_o  <= status_word;
                                    bus.wb_ack_o  <= 1'b1;
                                end
                            end
                            default: bus.wb_err_o <= 1'b1;
                        endcase
                    end
                end

                RD_WAIT: begin
                    state <= req ? RD_DONE : IDLE;
                end

                RD_DONE: begin
                    state <= IDLE;
                    if (req) begin
                        bus.wb_dat_o <= bus.buf_douta;
                        bus.wb_ack_o <= 1'b1;
                        // Zeroing a finished slot drops its busy bit so the
                        // master skips it, and frees it for a new command.
                        if (bus.buf_douta[31] && !empty) begin
                            bus.buf_addra <= rd_ptr;
                            bus.buf_dina  <= '0;
                            bus.buf_wea   <= 1'b1;
                            rd_ptr        <= rd_ptr + 1'b1;
                            count         <= count - 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_wb_cmd_if.sv
// Directed bench for spi_wb_cmd_if: one AW=8 and one AW=2 instance share the
// Wishbone stimulus, each with its own model of the command buffer.
module tb_spi_wb_cmd_if;
    logic        clk;
    logic        rst;
    logic        sel;       // 0 = AW=8 instance, 1 = AW=2 instance
    logic        cyc, stb, we;
    logic [1:0]  adr;
    logic [31:0] dat_w;
    logic        mw_en;
    logic [7:0]  mw_addr;
    logic [31:0] mw_data;

    int checks = 0;
    int errors = 0;

    spi_wb_cmd_if_if #(.AW(8)) b8 ();
    spi_wb_cmd_if_if #(.AW(2)) b2 ();

    spi_wb_cmd_if #(.AW(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
    spi_wb_cmd_if #(.AW(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    assign b8.wb_cyc_i = cyc & ~sel;
    assign b2.wb_cyc_i = cyc & sel;
    assign b8.wb_stb_i = stb;
    assign b2.wb_stb_i = stb;
    assign b8.wb_we_i  = we;
    assign b2.wb_we_i  = we;
    assign b8.wb_adr_i = adr;
    assign b2.wb_adr_i = adr;
    assign b8.wb_dat_i = dat_w;
    assign b2.wb_dat_i = dat_w;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer models: one-cycle read latency, plus a port for the "SPI master".
    logic [31:0] mem8 [256];
    logic [31:0] mem2 [4];
    always @(posedge clk) begin
        if (b8.buf_wea) mem8[b8.buf_addra] <= b8.buf_dina;
        if (mw_en && !sel) mem8[mw_addr] <= mw_data;
        b8.buf_douta <= mem8[b8.buf_addra];
        if (b2.buf_wea) mem2[b2.buf_addra] <= b2.buf_dina;
        if (mw_en && sel) mem2[mw_addr[1:0]] <= mw_data;
        b2.buf_douta <= mem2[b2.buf_addra];
    end

    logic        m_ack, m_err, m_wea;
    logic [31:0] m_dat, m_dina;
    logic [7:0]  m_addra;
    always_comb begin
        if (sel) begin
            m_ack = b2.wb_ack_o; m_err = b2.wb_err_o; m_wea = b2.buf_wea;
            m_dat = b2.wb_dat_o; m_dina = b2.buf_dina; m_addra = {6'b0, b2.buf_addra};
        end else begin
            m_ack = b8.wb_ack_o; m_err = b8.wb_err_o; m_wea = b8.buf_wea;
            m_dat = b8.wb_dat_o; m_dina = b8.buf_dina; m_addra = b8.buf_addra;
        end
    end

    // Pulse-shape monitor on both instances, event counters on the selected one.
    int   viol = 0;
    int   ack_seen = 0, wea_seen = 0;
    logic p_ack8 = 0, p_err8 = 0, p_wea8 = 0, p_ack2 = 0, p_err2 = 0, p_wea2 = 0;
    always @(negedge clk) begin
        if (m_ack) ack_seen <= ack_seen + 1;
        if (m_wea) wea_seen <= wea_seen + 1;
        if ((b8.wb_ack_o && b8.wb_err_o) || (b2.wb_ack_o && b2.wb_err_o)) viol <= viol + 1;
        if ((b8.wb_ack_o && p_ack8) || (b8.wb_err_o && p_err8) || (b8.buf_wea && p_wea8)) viol <= viol + 1;
        if ((b2.wb_ack_o && p_ack2) || (b2.wb_err_o && p_err2) || (b2.buf_wea && p_wea2)) viol <= viol + 1;
        p_ack8 <= b8.wb_ack_o; p_err8 <= b8.wb_err_o; p_wea8 <= b8.buf_wea;
        p_ack2 <= b2.wb_ack_o; p_err2 <= b2.wb_err_o; p_wea2 <= b2.buf_wea;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        sel;
        logic        mw;
        logic [7:0]  mw_addr;
        logic [31:0] mw_data;
        logic        we;
        logic [1:0]  adr;
        logic [31:0] dat;
        logic        exp_ack;
        logic        exp_err;
        int          exp_lat;
        logic        chk_dat;
        logic [31:0] exp_dat;
        logic        exp_wea;
        logic [7:0]  exp_addra;
        logic [31:0] exp_dina;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t wr_cmd(input logic s, input logic [31:0] d,
                                    input logic [7:0] a, input logic [31:0] dina);
        return '{s, 1'b0, 8'h0, 32'h0, 1'b1, 2'd0, d, 1'b1, 1'b0, 1, 1'b0, 32'h0, 1'b1, a, dina};
    endfunction

    function automatic vec_t bad(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d);
        return '{s, 1'b0, 8'h0, 32'h0, w, a, d, 1'b0, 1'b1, 1, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0};
    endfunction

    function automatic vec_t rd_status(input logic s, input logic [31:0] exp);
        return '{s, 1'b0, 8'h0, 32'h0, 1'b0, 2'd2, 32'h0, 1'b1, 1'b0, 1, 1'b1, exp, 1'b0, 8'h0, 32'h0};
    endfunction

    function automatic vec_t rd_result(input logic s, input logic mw, input logic [7:0] ma,
                                       input logic [31:0] md, input logic [31:0] exp,
                                       input logic wea, input logic [7:0] a);
        return '{s, mw, ma, md, 1'b0, 2'd1, 32'h0, 1'b1, 1'b0, 3, 1'b1, exp, wea, a, 32'h0};
    endfunction

    task automatic master_write(input logic [7:0] a, input logic [31:0] d);
        mw_addr = a; mw_data = d; mw_en = 1'b1;
        @(negedge clk);
        mw_en = 1'b0;
    endtask

    task automatic xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                        output logic ack_s, output logic err_s, output logic [31:0] dat_s,
                        output logic wea_s, output logic [7:0] addra_s,
                        output logic [31:0] dina_s, output int lat);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
        lat = 0;
        ack_s = 1'b0; err_s = 1'b0; dat_s = '0; wea_s = 1'b0; addra_s = '0; dina_s = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lat++;
            if (m_ack || m_err) break;
        end
        ack_s = m_ack; err_s = m_err; dat_s = m_dat;
        wea_s = m_wea; addra_s = m_addra; dina_s = m_dina;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic status_expect(input string name, input logic [31:0] exp);
        logic a, e, wv; logic [31:0] d, di; logic [7:0] ad; int l;
        xfer(1'b0, 2'd2, 32'h0, a, e, d, wv, ad, di, l);
        check({name, "_ack"}, a, 1'b1);
        check({name, "_dat"}, d, exp);
    endtask

    task automatic abort_read(input string name, input int hold, input logic drop_cyc);
        int a0, w0;
        a0 = ack_seen; w0 = wea_seen;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd1;
        repeat (hold) @(negedge clk);
        if (drop_cyc) cyc = 1'b0; else stb = 1'b0;
        repeat (5) @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check({name, "_no_ack"}, 32'(ack_seen - a0), 32'd0);
        check({name, "_no_wea"}, 32'(wea_seen - w0), 32'd0);
        status_expect({name, "_status"}, 32'h0000_0011);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic a, e, wv; logic [31:0] d, di; logic [7:0] ad; int l; int a0;

        // AW=8: single command, illegal accesses, not-ready and ready RESULT reads.
        vecs.push_back(wr_cmd(1'b0, 32'h2000_00A5, 8'd0, 32'h6000_00A5));
        vecs.push_back(rd_status(1'b0, 32'h0001_0001));
        vecs.push_back(bad(1'b0, 1'b1, 2'd1, 32'h1234_5678));
        vecs.push_back(bad(1'b0, 1'b1, 2'd2, 32'hFFFF_FFFF));
        vecs.push_back(bad(1'b0, 1'b0, 2'd3, 32'h0));
        vecs.push_back(bad(1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF));
        vecs.push_back(rd_status(1'b0, 32'h0001_0001));
        vecs.push_back(rd_result(1'b0, 1'b0, 8'd0, 32'h0, 32'h6000_00A5, 1'b0, 8'd0));
        vecs.push_back(rd_status(1'b0, 32'h0001_0001));
        vecs.push_back(rd_result(1'b0, 1'b1, 8'd0, 32'hC000_5A25, 32'hC000_5A25, 1'b1, 8'd0));
        vecs.push_back(rd_status(1'b0, 32'h4000_0101));
        vecs.push_back(rd_result(1'b0, 1'b1, 8'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 8'd1));
        vecs.push_back(rd_status(1'b0, 32'h4000_0101));
        // AW=2: fill, overflow, drain with clears, pointer wrap.
        vecs.push_back(wr_cmd(1'b1, 32'hFFFF_FFFF, 8'd0, 32'h6000_7FFF));
        vecs.push_back(wr_cmd(1'b1, 32'h0000_0011, 8'd1, 32'h4000_0011));
        vecs.push_back(wr_cmd(1'b1, 32'h1FFF_8022, 8'd2, 32'h4000_0022));
        vecs.push_back(wr_cmd(1'b1, 32'h2000_0033, 8'd3, 32'h6000_0033));
        vecs.push_back(bad(1'b1, 1'b1, 2'd0, 32'h0000_0044));
        vecs.push_back(rd_status(1'b1, 32'h8000_0040));
        for (int k = 0; k < 4; k++)
            vecs.push_back(rd_result(1'b1, 1'b1, 8'(k), 32'h8000_0100 + 32'(k),
                                     32'h8000_0100 + 32'(k), 1'b1, 8'(k)));
        vecs.push_back(rd_status(1'b1, 32'h4000_0000));
        vecs.push_back(wr_cmd(1'b1, 32'h0000_0005, 8'd0, 32'h4000_0005));
        vecs.push_back(rd_status(1'b1, 32'h0000_0011));

        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0;
        sel = 1'b0; mw_en = 1'b0; mw_addr = '0; mw_data = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_ack", b8.wb_ack_o, 1'b0);
        check("reset_err", b8.wb_err_o, 1'b0);
        check("reset_dat", b8.wb_dat_o, 32'h0);
        check("reset_wea", b8.buf_wea, 1'b0);
        check("reset_addra", b8.buf_addra, 8'h0);
        check("reset_dina", b8.buf_dina, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            if (vecs[i].mw) master_write(vecs[i].mw_addr, vecs[i].mw_data);
            xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, a, e, d, wv, ad, di, l);
            check($sformatf("v%0d_ack", i), a, vecs[i].exp_ack);
            check($sformatf("v%0d_err", i), e, vecs[i].exp_err);
            check($sformatf("v%0d_latency", i), 32'(l), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_wea", i), wv, vecs[i].exp_wea);
            if (vecs[i].chk_dat) check($sformatf("v%0d_dat", i), d, vecs[i].exp_dat);
            if (vecs[i].exp_wea) begin
                check($sformatf("v%0d_addra", i), ad, vecs[i].exp_addra);
                check($sformatf("v%0d_dina", i), di, vecs[i].exp_dina);
            end
        end
        check("aw8_slot0_cleared", mem8[0], 32'h0);
        check("aw2_slot0_new_cmd", mem2[0], 32'h4000_0005);

        // Aborts on the AW=2 instance with a ready word waiting in slot 0.
        sel = 1'b1;
        master_write(8'd0, 32'hC000_0005);
        abort_read("abort_rd_wait", 1, 1'b1);
        abort_read("abort_rd_done", 2, 1'b0);

        // Reset while a RESULT read sits in RD_WAIT.
        a0 = ack_seen;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd1;
        @(negedge clk);
        rst = 1'b1;
        cyc = 1'b0; stb = 1'b0;
        #1;
        check("rst_mid_ack", b2.wb_ack_o, 1'b0);
        check("rst_mid_err", b2.wb_err_o, 1'b0);
        check("rst_mid_dat", b2.wb_dat_o, 32'h0);
        check("rst_mid_wea", b2.buf_wea, 1'b0);
        check("rst_mid_addra", {6'b0, b2.buf_addra}, 8'h0);
        check("rst_mid_dina", b2.buf_dina, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_no_ack", 32'(ack_seen - a0), 32'd0);
        status_expect("rst_mid_status", 32'h4000_0000);

        @(negedge clk);
        check("pulse_rules", 32'(viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
